mdu_core: RTL

Multiply/divide unit for the E stage of the 5-stage pipeline. It executes MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations and holds the HI/LO registers. It also accepts MTHI/MTLO writes. It drives the `busy` signal that the hazard logic combines with `start` to stall any MDU-using instruction in D.

---
 rtl/mdu_core.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mdu_core.sv
// mdu_core: fixed-latency multiply/divide unit holding HI/LO, with MTHI/MTLO writes.
// Optional macro MDU_DIV0_HOLD_EN: divide-by-zero leaves HI/LO unchanged at completion.
module mdu_core #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mt_we,
    input  logic        mt_hi,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        mt_accept;
    logic        div0;
    logic        div_ovf;
    logic [31:0] b_safe_s;
    logic [31:0] b_safe_u;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quo_s, rem_s;
    logic [31:0] quo_u, rem_u;
    logic [63:0] res_new;

    assign accept    = start & ~req & ~busy_q;
    assign mt_accept = mt_we & ~start & ~req & ~busy_q;

    // Low 64 bits of the product of sign-extended operands is the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor is forced to 1 for the zero and INT_MIN/-1 cases so the dividers
    // never see an undefined operation; INT_MIN/1 already yields the required result.
    assign div0     = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign b_safe_s = (div0 || div_ovf) ? 32'd1 : B;
    assign b_safe_u = div0 ? 32'd1 : B;
    assign quo_s    = 32'($signed(A) / $signed(b_safe_s));
    assign rem_s    = 32'($signed(A) % $signed(b_safe_s));
    assign quo_u    = A / b_safe_u;
    assign rem_u    = A % b_safe_u;

    always_comb begin
        res_new = 64'd0;
        case (op)
            2'b00:   res_new = prod_s;
            2'b01:   res_new = prod_u;
            2'b10:   res_new = {rem_s, quo_s};
            default: res_new = {rem_u, quo_u};
        endcase
        // HI/LO cannot change while busy, so latching them now holds them at completion.
        if (op[1] && div0) begin
`ifdef MDU_DIV0_HOLD_EN
            res_new = {hi_q, lo_q};
`else
            res_new = {A, 32'hFFFF_FFFF};
`endif
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (busy_q) begin
            if (cnt_q == 4'd1) begin
                hi_d   = res_hi_q;
                lo_d   = res_lo_q;
                busy_d = 1'b0;
                cnt_d  = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (accept) begin
            res_hi_d = res_new[63:32];
            res_lo_d = res_new[31:0];
            cnt_d    = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy_d   = 1'b1;
        end else if (mt_accept) begin
            if (mt_hi) hi_d = A;
            else       lo_d = A;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
